// File: rtl/he_cmd_queue.sv
// Wishbone-mapped command FIFO feeding the LWE core one instruction at a time, with completion status and irq.
// Latency: ack 1 cycle after strobe, push takes effect on the ack edge, cmd_* driven combinationally from the FIFO head.
// Backpressure: head held on cmd_* until cmd_ready_i; a push into a full FIFO with no same-edge pop is dropped and flags overflow.
module he_cmd_queue #(
  parameter logic [31:0] CMDQ_BASE      = 32'h3000_0800,
  parameter int          ADDR_WIDTH     = 9,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          DONE_CNT_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [1:0]            cmd_op_o,
  output logic [ADDR_WIDTH-1:0] cmd_src0_o,
  output logic [ADDR_WIDTH-1:0] cmd_src1_o,
  output logic [ADDR_WIDTH-1:0] cmd_dest_o,
  input  logic                  core_done_i,
  output logic                  irq_o
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = 2 + 3 * ADDR_WIDTH;
  localparam int DW8 = (DONE_CNT_WIDTH < 8) ? DONE_CNT_WIDTH : 8;

  if (EW > 31) begin : g_bad_addr_width
    $error("he_cmd_queue: 2+3*ADDR_WIDTH must not exceed 31");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 128 || (1 << PW) != FIFO_DEPTH) begin : g_bad_depth
    $error("he_cmd_queue: FIFO_DEPTH must be a power of two in 2..128");
  end

  logic [EW-1:0]             mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;
  logic                      busy, overflow, spurious, irq_en;
  logic [DONE_CNT_WIDTH-1:0] done_cnt;
  logic [31:0]               rdata;
  logic [EW-1:0]             head;

  // Bus decode: an access completes on the edge where ack is already high
  logic       hit, acc_wr;
  logic [1:0] off;
  assign hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == CMDQ_BASE[31:4]);
  assign acc_wr = hit && wbs_ack_o && wbs_we_i;
  assign off    = wbs_adr_i[3:2];

  logic push_req, ctrl_wr, flush, clr_ovf, ld_ien, clr_done, clr_spur;
  assign push_req = acc_wr && (off == 2'd0) && wbs_dat_i[31];
  assign ctrl_wr  = acc_wr && (off == 2'd2);
  assign clr_ovf  = ctrl_wr && wbs_dat_i[0];
  assign flush    = ctrl_wr && wbs_dat_i[1];
  assign ld_ien   = ctrl_wr && wbs_dat_i[2];
  assign clr_done = ctrl_wr && wbs_dat_i[4];
  assign clr_spur = ctrl_wr && wbs_dat_i[5];

  logic empty, full, pop, push, ovf_set;
  assign empty       = (count == '0);
  assign full        = (count == CW'(FIFO_DEPTH));
  assign cmd_valid_o = !empty && !busy;
  assign pop         = cmd_valid_o && cmd_ready_i;
  assign push        = push_req && (!full || pop);
  assign ovf_set     = push_req && full && !pop;

  // Head fields are zeroed while the FIFO is empty so the core never sees stale entries
  assign head       = empty ? '0 : mem[rd_ptr];
  assign cmd_op_o   = head[1:0];
  assign cmd_src0_o = head[2 +: ADDR_WIDTH];
  assign cmd_src1_o = head[2 + ADDR_WIDTH +: ADDR_WIDTH];
  assign cmd_dest_o = head[2 + 2 * ADDR_WIDTH +: ADDR_WIDTH];

  // sel, low address bits and the unused top of the write word carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

  // Command storage; contents are don't-care until pointed at, so no reset
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wbs_dat_i[EW-1:0];
  end

  // FIFO pointers and occupancy; flush drops everything, a same-edge pop has already dispatched its entry
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // In-flight tracking, completion counter, sticky flags and the registered interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      busy     <= 1'b0;
      done_cnt <= '0;
      overflow <= 1'b0;
      spurious <= 1'b0;
      irq_en   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (pop)              busy <= 1'b1;
      else if (core_done_i) busy <= 1'b0;

      if (clr_done)
        done_cnt <= '0;
      else if (core_done_i && busy && done_cnt != {DONE_CNT_WIDTH{1'b1}})
        done_cnt <= done_cnt + DONE_CNT_WIDTH'(1);

      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (core_done_i && !busy) spurious <= 1'b1;
      else if (clr_spur)        spurious <= 1'b0;

      if (ld_ien) irq_en <= wbs_dat_i[3];

      irq_o <= irq_en && ((done_cnt != '0) || overflow || spurious);
    end
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (off)
      2'd1: begin
        rdata[CW-1:0]    = count;
        rdata[8]         = empty;
        rdata[9]         = full;
        rdata[10]        = busy;
        rdata[11]        = overflow;
        rdata[12]        = spurious;
        rdata[16 +: DW8] = done_cnt[DW8-1:0];
        rdata[24]        = irq_en;
        rdata[31]        = irq_o;
      end
      2'd2:    rdata[0] = irq_en;
      default: rdata = '0;
    endcase
  end

  // Single-cycle ack per access; read data only valid alongside ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= hit && !wbs_ack_o;
      wbs_dat_o <= (hit && !wbs_ack_o) ? rdata : 32'h0;
    end
  end

endmodule

// File: doc/he_cmd_queue.md
Name: he_cmd_queue

Overview:
- Wishbone-mapped command queue that sits between the caravel Wishbone bus and the LWE compute core (encrypt/decrypt/add/multiply).
- Replaces the single start-bit opcode register with a parametrised FIFO, so firmware can post several instructions back to back.
- Dispatches queued instructions one at a time over a valid/ready handshake.
- Tracks completions and exposes status, sticky error flags and a level interrupt.

Parameters:
- CMDQ_BASE, 32'h30000800: Wishbone window base; 16-byte window, word offsets 0x0/0x4/0x8/0xC.
- ADDR_WIDTH, 9: width of each src0/src1/dest field. Elaboration error if 2+3*ADDR_WIDTH > 31.
- FIFO_DEPTH, 4: command entries. Power of two, 2..128.
- DONE_CNT_WIDTH, 8: width of the saturating completion counter.

Ports:
- wb_clk_i, input, 1: clock.
- wb_rst_n_i, input, 1: asynchronous active-low reset.
- wbs_stb_i, input, 1: Wishbone strobe.
- wbs_cyc_i, input, 1: Wishbone cycle.
- wbs_we_i, input, 1: write enable.
- wbs_sel_i, input, 4: byte selects. Ignored; full-word access only.
- wbs_adr_i, input, 32: byte address.
- wbs_dat_i, input, 32: write data.
- wbs_ack_o, output, 1: acknowledge.
- wbs_dat_o, output, 32: read data.
- cmd_valid_o, output, 1: FIFO head is presented to the core.
- cmd_ready_i, input, 1: core accepts the head.
- cmd_op_o, output, 2: opcode (00 enc, 01 dec, 10 add, 11 mul).
- cmd_src0_o, output, ADDR_WIDTH: source 0 address.
- cmd_src1_o, output, ADDR_WIDTH: source 1 address.
- cmd_dest_o, output, ADDR_WIDTH: destination address.
- core_done_i, input, 1: one-cycle pulse when the in-flight command completes.
- irq_o, output, 1: level interrupt.

Behaviour:
- Reset (async assert, sync release): FIFO empty, busy=0, all sticky flags 0, done_cnt=0, irq_en=0, wbs_ack_o=0, wbs_dat_o=0, cmd_valid_o=0, cmd fields 0, irq_o=0.
- Decode:
  - Hit when cyc&stb and wbs_adr_i[31:4]==CMDQ_BASE[31:4]; no hit means no ack.
  - Registered ack is asserted the cycle after a hit with ack=0, held one cycle, then drops. Back-to-back accesses therefore take 2 cycles each.
  - Read data is valid while ack is high and 0 otherwise.
- Offset 0x0 PUSH (write):
  - Field layout: [1:0] op, [2+AW-1:2] src0, [2+2AW-1:2+AW] src1, [2+3AW-1:2+2AW] dest, [31] start.
  - start=0: acked, ignored.
  - start=1: enqueued on the ack edge.
  - Reads of 0x0 return 0.
- Offset 0x4 STATUS (read-only; writes acked and ignored):
  - [7:0] FIFO count, [8] empty, [9] full, [10] busy.
  - [11] overflow (sticky), [12] spurious_done (sticky).
  - [23:16] done_cnt (low 8 bits), [24] irq_en, [31] irq_o.
- Offset 0x8 CTRL (write-1 actions; reads return {31'b0, irq_en}):
  - bit0: clear overflow.
  - bit1: flush FIFO.
  - bit2: load irq_en from bit3.
  - bit4: clear done_cnt.
  - bit5: clear spurious_done.
- Offset 0xC: reads 0, writes ignored.
- Overflow: push while full with no pop on the same edge drops the command and sets overflow. Push and pop on the same edge while full are both accepted; count is unchanged.
- Dispatch:
  - cmd_valid_o = !empty && !busy. Head fields drive the cmd_* outputs combinationally from the FIFO head; outputs are 0 when empty.
  - On cmd_valid_o && cmd_ready_i: pop and set busy=1.
  - cmd_valid_o must not drop before ready; the head is stable while valid.
- Completion:
  - core_done_i while busy: busy=0 and done_cnt increments, saturating at 2^DONE_CNT_WIDTH-1.
  - core_done_i while !busy: sets spurious_done; counter unchanged.
  - A new dispatch can occur at the earliest the cycle after busy clears (no same-edge redispatch).
- Flush: empties the FIFO only; an in-flight command still completes normally. If flush and a pop occur on the same edge, the popped command is dispatched and the rest are discarded.
- irq_o = irq_en && (done_cnt!=0 || overflow || spurious_done). Registered; updates the cycle after the cause.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap; count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-operation clears everything immediately, including busy. A subsequent core_done_i sets spurious_done.

Test Plan:
- Reset, then read 0x30000804 -> 0x00000100 (empty). cmd_valid_o=0, irq_o=0.
- Write 0x83232002 to 0x30000800 with cmd_ready_i=1 -> cmd_valid_o one cycle after ack with op=2, src0=0, src1=100, dest=50. Status busy=1, count=0. Pulse core_done_i -> done_cnt=1, busy=0.
- cmd_ready_i=0; push 5 commands with dest 1..5 (FIFO_DEPTH=4) -> status count=4, full=1, overflow=1. Raise ready and complete each -> dests dispatched in order 1,2,3,4; done_cnt=4.
- Write 0x00000000 to 0x30000800 -> acked, count stays 0, no dispatch.
- Write CTRL 0x0C (irq_en=1), then pulse core_done_i while idle -> spurious_done=1, irq_o=1. Write CTRL 0x30 -> irq_o=0 next cycle.
- Queue 3 commands with one in flight; write CTRL 0x02 -> count=0, busy stays 1. core_done_i completes the in-flight command; done_cnt increments by 1 and no further dispatch occurs.
